// File: rtl/fetch_stage_pkg.sv
// Shared constants and the F/D bundle layout for the MIPS fetch stage.
package fetch_stage_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam int          DEF_IM_WORDS = 4096;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc8;
    logic            valid;
    logic            adel;
  } fd_t;

endpackage

// File: rtl/fetch_stage_pipe_reg.sv
// One field of a pipeline register: async reset, hold when en=0, bubble on clr.
module pipe_reg #(
  parameter int          W       = 32,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: state is written with <= so every register samples pre-edge values
  // regardless of the order the simulator evaluates the always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    q <= CLR_VAL;
    else if (en)  q <= clr ? CLR_VAL : d;
  end

endmodule

// File: rtl/fetch_stage.sv
// F stage: PC register, instruction-memory address, F/D pipeline register
// and a count of valid instructions handed to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IM_WORDS = DEF_IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        clr_d,
  input  logic [31:0] npc,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] im_addr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        adel_d,
  output logic [31:0] fetch_cnt
);

  // One bit wider than the PC so the end of IM never wraps past 2^32.
  localparam logic [32:0] IM_END = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

  logic adel;
  fd_t  fd_next;

  assign im_addr = (pc_f - RESET_PC) & 32'hFFFF_FFFC;

  assign adel = (pc_f[1:0] != 2'b00) | (pc_f < RESET_PC) | ({1'b0, pc_f} >= IM_END);

  always_comb begin
    fd_next.instr = adel ? NOP : im_rdata;
    fd_next.pc    = pc_f;
    fd_next.pc8   = pc_f + 32'd8;
    fd_next.valid = 1'b1;
    fd_next.adel  = adel;
  end

  // NOTE: reset sits in the sensitivity list, so PC and counter clear the
  // moment reset rises rather than waiting for the next clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f      <= RESET_PC;
      fetch_cnt <= '0;
    end else if (!stall) begin
      pc_f <= npc;
      if (!clr_d) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  pipe_reg #(.W(XLEN), .CLR_VAL(NOP)) u_instr (
    .clk(clk), .reset(reset), .en(!stall), .clr(clr_d), .d(fd_next.instr), .q(instr_d)
  );

  pipe_reg #(.W(XLEN)) u_pc (
    .clk(clk), .reset(reset), .en(!stall), .clr(clr_d), .d(fd_next.pc), .q(pc_d)
  );

  pipe_reg #(.W(XLEN)) u_pc8 (
    .clk(clk), .reset(reset), .en(!stall), .clr(clr_d), .d(fd_next.pc8), .q(pc8_d)
  );

  pipe_reg #(.W(1)) u_valid (
    .clk(clk), .reset(reset), .en(!stall), .clr(clr_d), .d(fd_next.valid), .q(valid_d)
  );

  pipe_reg #(.W(1)) u_adel (
    .clk(clk), .reset(reset), .en(!stall), .clr(clr_d), .d(fd_next.adel), .q(adel_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequential fetch, stall, clear,
// address-error detection and counter wrap.
module tb_fetch_stage;

  localparam logic [31:0] INS_A = 32'h2408_0001;
  localparam logic [31:0] INS_B = 32'h2409_0002;
  localparam logic [31:0] INS_C = 32'h012A_5020;

  logic        clk = 1'b0;
  logic        reset, stall, clr_d;
  logic [31:0] npc, im_rdata;
  logic [31:0] pc_f, im_addr, instr_d, pc_d, pc8_d, fetch_cnt;
  logic        valid_d, adel_d;

  logic [31:0] imem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .clr_d(clr_d), .npc(npc),
    .im_rdata(im_rdata), .pc_f(pc_f), .im_addr(im_addr), .instr_d(instr_d),
    .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d), .adel_d(adel_d),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  assign im_rdata = (im_addr < 32'h0000_4000) ? imem[im_addr[13:2]] : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; clr_d = 1'b0; npc = 32'h3000;
    #1;
    n_checks++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL reset_pc_f got %h want %h", pc_f, 32'h3000); end
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_d); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", fetch_cnt); end
    n_checks++; if ({instr_d, pc_d, pc8_d, adel_d} !== 97'd0) begin n_fail++; $display("FAIL reset_fd got %h %h %h %b want zeros", instr_d, pc_d, pc8_d, adel_d); end
    n_checks++; if (im_addr !== 32'd0) begin n_fail++; $display("FAIL reset_im_addr got %h want 0", im_addr); end
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_fetch_seq();
    npc = 32'h3004; tick();
    n_checks++; if (instr_d !== INS_A) begin n_fail++; $display("FAIL seq0_instr got %h want %h", instr_d, INS_A); end
    n_checks++; if (pc_d !== 32'h3000) begin n_fail++; $display("FAIL seq0_pc_d got %h want 3000", pc_d); end
    n_checks++; if (pc8_d !== 32'h3008) begin n_fail++; $display("FAIL seq0_pc8 got %h want 3008", pc8_d); end
    n_checks++; if ({valid_d, adel_d} !== 2'b10) begin n_fail++; $display("FAIL seq0_flags got %b%b want 10", valid_d, adel_d); end
    n_checks++; if (pc_f !== 32'h3004) begin n_fail++; $display("FAIL seq0_pc_f got %h want 3004", pc_f); end
    npc = 32'h3008; tick();
    n_checks++; if (instr_d !== INS_B) begin n_fail++; $display("FAIL seq1_instr got %h want %h", instr_d, INS_B); end
    n_checks++; if (pc8_d !== 32'h300C) begin n_fail++; $display("FAIL seq1_pc8 got %h want 300c", pc8_d); end
    npc = 32'h300C; tick();
    n_checks++; if (instr_d !== INS_C) begin n_fail++; $display("FAIL seq2_instr got %h want %h", instr_d, INS_C); end
    n_checks++; if (pc8_d !== 32'h3010) begin n_fail++; $display("FAIL seq2_pc8 got %h want 3010", pc8_d); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL seq2_cnt got %0d want 3", fetch_cnt); end
    n_checks++; if (im_addr !== 32'h0000_000C) begin n_fail++; $display("FAIL seq2_im_addr got %h want c", im_addr); end
  endtask

  task automatic test_mid_reset();
    npc = 32'h3010; tick();
    n_checks++; if (pc_f !== 32'h3010) begin n_fail++; $display("FAIL mid_pre_pc_f got %h want 3010", pc_f); end
    n_checks++; if (fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL mid_pre_cnt got %0d want 4", fetch_cnt); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (pc_f !== 32'h3000) begin n_fail++; $display("FAIL mid_rst_pc_f got %h want 3000", pc_f); end
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", valid_d); end
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rst_cnt got %0d want 0", fetch_cnt); end
    n_checks++; if (instr_d !== 32'd0) begin n_fail++; $display("FAIL mid_rst_instr got %h want 0", instr_d); end
    #2 reset = 1'b0;
    npc = 32'h3004; tick();
    n_checks++; if (pc_d !== 32'h3000) begin n_fail++; $display("FAIL mid_first_pc_d got %h want 3000", pc_d); end
    n_checks++; if (instr_d !== INS_A) begin n_fail++; $display("FAIL mid_first_instr got %h want %h", instr_d, INS_A); end
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL mid_first_cnt got %0d want 1", fetch_cnt); end
  endtask

  task automatic test_stall();
    npc = 32'h3008; tick();
    n_checks++; if (pc_f !== 32'h3008) begin n_fail++; $display("FAIL stall_pre_pc_f got %h want 3008", pc_f); end
    stall = 1'b1; npc = 32'h3100;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc_f !== 32'h3008) begin n_fail++; $display("FAIL stall%0d_pc_f got %h want 3008", i, pc_f); end
      n_checks++; if (instr_d !== INS_B) begin n_fail++; $display("FAIL stall%0d_instr got %h want %h", i, instr_d, INS_B); end
      n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL stall%0d_cnt got %0d want 2", i, fetch_cnt); end
      n_checks++; if ({pc_d, valid_d} !== {32'h3004, 1'b1}) begin n_fail++; $display("FAIL stall%0d_fd got %h/%b want 3004/1", i, pc_d, valid_d); end
    end
    clr_d = 1'b1; tick();
    n_checks++; if ({instr_d, valid_d} !== {INS_B, 1'b1}) begin n_fail++; $display("FAIL stall_clr_fd got %h/%b want %h/1", instr_d, valid_d, INS_B); end
    n_checks++; if (pc_f !== 32'h3008) begin n_fail++; $display("FAIL stall_clr_pc_f got %h want 3008", pc_f); end
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL stall_clr_cnt got %0d want 2", fetch_cnt); end
    stall = 1'b0; clr_d = 1'b0;
  endtask

  task automatic test_clear();
    clr_d = 1'b1; npc = 32'h3040; tick();
    n_checks++; if (pc_f !== 32'h3040) begin n_fail++; $display("FAIL clr_pc_f got %h want 3040", pc_f); end
    n_checks++; if (instr_d !== 32'd0) begin n_fail++; $display("FAIL clr_instr got %h want 0", instr_d); end
    n_checks++; if (valid_d !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b want 0", valid_d); end
    n_checks++; if ({pc_d, pc8_d, adel_d} !== 65'd0) begin n_fail++; $display("FAIL clr_fd got %h %h %b want zeros", pc_d, pc8_d, adel_d); end
    n_checks++; if (fetch_cnt !== 32'd2) begin n_fail++; $display("FAIL clr_cnt got %0d want 2", fetch_cnt); end
    clr_d = 1'b0;
  endtask

  task automatic test_adel();
    npc = 32'h3002; tick();
    n_checks++; if ({instr_d, adel_d, valid_d} !== {32'hDEAD_0010, 1'b0, 1'b1}) begin n_fail++; $display("FAIL adel_ok_fd got %h/%b/%b want dead0010/0/1", instr_d, adel_d, valid_d); end
    n_checks++; if (fetch_cnt !== 32'd3) begin n_fail++; $display("FAIL adel_ok_cnt got %0d want 3", fetch_cnt); end
    npc = 32'h2FFC; tick();
    n_checks++; if ({instr_d, adel_d, valid_d} !== {32'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL adel_mis_fd got %h/%b/%b want 0/1/1", instr_d, adel_d, valid_d); end
    n_checks++; if ({pc_d, pc8_d} !== {32'h3002, 32'h300A}) begin n_fail++; $display("FAIL adel_mis_pc got %h/%h want 3002/300a", pc_d, pc8_d); end
    n_checks++; if (pc_f !== 32'h2FFC) begin n_fail++; $display("FAIL adel_mis_pc_f got %h want 2ffc", pc_f); end
    npc = 32'h3000; tick();
    n_checks++; if ({instr_d, adel_d, valid_d} !== {32'd0, 1'b1, 1'b1}) begin n_fail++; $display("FAIL adel_low_fd got %h/%b/%b want 0/1/1", instr_d, adel_d, valid_d); end
    n_checks++; if (fetch_cnt !== 32'd5) begin n_fail++; $display("FAIL adel_low_cnt got %0d want 5", fetch_cnt); end
    npc = 32'h6FFC; tick();
    n_checks++; if ({instr_d, adel_d} !== {INS_A, 1'b0}) begin n_fail++; $display("FAIL adel_base_fd got %h/%b want %h/0", instr_d, adel_d, INS_A); end
    npc = 32'h7000; tick();
    n_checks++; if ({instr_d, adel_d} !== {32'hDEAD_0FFF, 1'b0}) begin n_fail++; $display("FAIL adel_top_fd got %h/%b want dead0fff/0", instr_d, adel_d); end
    npc = 32'hFFFF_FFFC; tick();
    n_checks++; if ({instr_d, adel_d, pc_d} !== {32'd0, 1'b1, 32'h7000}) begin n_fail++; $display("FAIL adel_end_fd got %h/%b/%h want 0/1/7000", instr_d, adel_d, pc_d); end
    npc = 32'h3000; tick();
    n_checks++; if ({pc8_d, adel_d} !== {32'h0000_0004, 1'b1}) begin n_fail++; $display("FAIL adel_wrap_pc8 got %h/%b want 4/1", pc8_d, adel_d); end
    n_checks++; if (fetch_cnt !== 32'd9) begin n_fail++; $display("FAIL adel_wrap_cnt got %0d want 9", fetch_cnt); end
  endtask

  task automatic test_cnt_wrap();
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    npc = 32'h3004; tick();
    n_checks++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap got %h want 0", fetch_cnt); end
    n_checks++; if ({instr_d, valid_d} !== {INS_A, 1'b1}) begin n_fail++; $display("FAIL cnt_wrap_fd got %h/%b want %h/1", instr_d, valid_d, INS_A); end
    npc = 32'h3008; tick();
    n_checks++; if (fetch_cnt !== 32'd1) begin n_fail++; $display("FAIL cnt_after_wrap got %h want 1", fetch_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) imem[i] = 32'hDEAD_0000 | 32'(i);
    imem[0] = INS_A;
    imem[1] = INS_B;
    imem[2] = INS_C;
    test_reset();
    test_fetch_seq();
    test_mid_reset();
    test_stall();
    test_clear();
    test_adel();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
